// File: rtl/key_press_conditioner.sv
// Push-button front end for the digital lock: synchronise, debounce, one-hot key events.
// Optional auto-repeat while a key is held: define KEY_REPEAT_EN.
module key_press_conditioner #(
  parameter int KEYS            = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [KEYS-1:0] key_n,
  output logic [KEYS-1:0] key,
  output logic            key_held,
  output logic            key_error
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    DB_PRESS,
    PRESSED,
    DB_RELEASE,
    WAIT_RELEASE
  } state_t;

  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 1) begin : g_bad_params
    $error("key_press_conditioner: parameter out of range");
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    return (value == {CNT_W{1'b1}}) ? value : value + CNT_W'(1);
  endfunction

  function automatic logic multi_hot(input logic [KEYS-1:0] value);
    return |(value & (value - KEYS'(1)));
  endfunction

  logic [SYNC_STAGES-1:0][KEYS-1:0] sync_p;
  logic [KEYS-1:0]  p;
  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [KEYS-1:0]  code, code_next;
  logic [KEYS-1:0]  key_d;
  logic             key_held_d;
  logic             key_error_d;
  logic             repeat_fire;

  // Synchroniser stages: idle value is "released" so reset never looks like a press
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_p <= {SYNC_STAGES{{KEYS{1'b1}}}};
    end else begin
      sync_p <= {sync_p[SYNC_STAGES-2:0], key_n};
    end
  end

  assign p = ~sync_p[SYNC_STAGES-1];

`ifdef KEY_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYCLES) + 1;
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

  logic [REP_W-1:0] rep_cnt;

  // Only uninterrupted time in PRESSED counts towards a repeat
  always_ff @(posedge clock) begin
    if (reset) begin
      rep_cnt <= '0;
    end else if (state != PRESSED || p == '0 || rep_cnt == REP_LAST) begin
      rep_cnt <= '0;
    end else begin
      rep_cnt <= rep_cnt + REP_W'(1);
    end
  end

  assign repeat_fire = (state == PRESSED) && (p != '0) && (rep_cnt == REP_LAST);
`else
  assign repeat_fire = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      code  <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      code  <= code_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    code_next  = code;
    case (state)
      IDLE: begin
        if (p != '0) begin
          cnt_next = '0;
          if (multi_hot(p)) begin
            state_next = WAIT_RELEASE;
          end else begin
            code_next  = p;
            state_next = DB_PRESS;
          end
        end
      end
      DB_PRESS: begin
        if (p != code) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt == DB_LAST) begin
          state_next = PRESSED;
          cnt_next   = '0;
        end else begin
          cnt_next = sat_inc(cnt);
        end
      end
      PRESSED: begin
        if (p == '0) begin
          state_next = DB_RELEASE;
          cnt_next   = '0;
        end
      end
      DB_RELEASE: begin
        if (p != '0) begin
          state_next = PRESSED;
          cnt_next   = '0;
        end else if (cnt == DB_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = sat_inc(cnt);
        end
      end
      WAIT_RELEASE: begin
        if (p != '0) begin
          cnt_next = '0;
        end else if (cnt == DB_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = sat_inc(cnt);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // The captured code is one-hot by construction, so key can never be multi-hot
  always_comb begin
    key_d = '0;
    if ((state == DB_PRESS && p == code && cnt == DB_LAST) || repeat_fire) begin
      key_d = code;
    end
    key_held_d  = (state_next == PRESSED) || (state_next == DB_RELEASE);
    key_error_d = (state == IDLE) && multi_hot(p);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      key       <= '0;
      key_held  <= 1'b0;
      key_error <= 1'b0;
    end else begin
      key       <= key_d;
      key_held  <= key_held_d;
      key_error <= key_error_d;
    end
  end

endmodule

// File: tb/tb_key_press_conditioner.sv
// Directed bench for key_press_conditioner with SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8.
module tb_key_press_conditioner;

`ifdef KEY_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic       clock;
  logic       reset;
  logic [3:0] key_n;
  logic [3:0] key;
  logic       key_held;
  logic       key_error;

  int checks = 0;
  int errors = 0;

  key_press_conditioner #(
    .KEYS(4),
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_CYCLES(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .key_n(key_n),
    .key(key),
    .key_held(key_held),
    .key_error(key_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  // Inputs change 1 time unit after an edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    key_n = 4'b1111;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    key_n = 4'b1111;
    repeat (2) tick();
    reset = 1'b0;
    checks++;
    if ({key, key_held, key_error} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b required 000000", {key, key_held, key_error});
    end
    for (int e = 1; e <= 20; e++) begin
      tick();
      checks++;
      if ({key, key_held, key_error} !== 6'b0) begin
        errors++;
        $display("FAIL reset_idle e=%0d: got %b required 000000", e, {key, key_held, key_error});
      end
    end
  endtask

  task automatic test_press();
    logic [3:0] exp_key;
    key_n = 4'b1101;
    for (int e = 1; e <= 20; e++) begin
      tick();
      exp_key = (e == 7 || (REP && e == 15)) ? 4'b0010 : 4'b0000;
      checks++;
      if (key !== exp_key) begin
        errors++;
        $display("FAIL press_key e=%0d: got %b required %b", e, key, exp_key);
      end
      checks++;
      if (key_held !== (e >= 7)) begin
        errors++;
        $display("FAIL press_held e=%0d: got %b required %b", e, key_held, (e >= 7));
      end
    end
    key_n = 4'b1111;
    for (int e = 1; e <= 10; e++) begin
      tick();
      checks++;
      if (key !== 4'b0000 || key_held !== (e < 7)) begin
        errors++;
        $display("FAIL press_release e=%0d: got key=%b held=%b required key=0000 held=%b",
                 e, key, key_held, (e < 7));
      end
    end
  endtask

  task automatic test_press_bounce();
    logic [3:0] pat [6];
    pat = '{4'b1110, 4'b1110, 4'b1111, 4'b1110, 4'b1110, 4'b1111};
    for (int e = 1; e <= 18; e++) begin
      if (e <= 6) key_n = pat[e-1];
      tick();
      checks++;
      if (key !== 4'b0000 || key_held !== 1'b0) begin
        errors++;
        $display("FAIL press_bounce e=%0d: got key=%b held=%b required key=0000 held=0",
                 e, key, key_held);
      end
    end
    // A clean press right after must see the full latency, proving IDLE was regained
    key_n = 4'b1110;
    for (int e = 1; e <= 8; e++) begin
      tick();
      checks++;
      if (key !== ((e == 7) ? 4'b0001 : 4'b0000)) begin
        errors++;
        $display("FAIL bounce_recover e=%0d: got %b required %b", e, key,
                 ((e == 7) ? 4'b0001 : 4'b0000));
      end
    end
    idle(10);
  endtask

  task automatic test_multi_key();
    key_n = 4'b1100;
    for (int e = 1; e <= 6; e++) begin
      tick();
      checks++;
      if (key_error !== (e == 3) || key !== 4'b0000 || key_held !== 1'b0) begin
        errors++;
        $display("FAIL multi_error e=%0d: got err=%b key=%b held=%b required err=%b key=0000 held=0",
                 e, key_error, key, key_held, (e == 3));
      end
    end
    key_n = 4'b1110;
    for (int e = 1; e <= 10; e++) begin
      tick();
      checks++;
      if ({key, key_held, key_error} !== 6'b0) begin
        errors++;
        $display("FAIL multi_drop_to_one e=%0d: got %b required 000000", e, {key, key_held, key_error});
      end
    end
    // Only three released cycles: still WAIT_RELEASE, so the next press is ignored
    key_n = 4'b1111;
    repeat (3) tick();
    key_n = 4'b1110;
    for (int e = 1; e <= 12; e++) begin
      tick();
      checks++;
      if ({key, key_held, key_error} !== 6'b0) begin
        errors++;
        $display("FAIL multi_short_release e=%0d: got %b required 000000", e, {key, key_held, key_error});
      end
    end
    key_n = 4'b1111;
    repeat (4) tick();
    key_n = 4'b1110;
    for (int e = 1; e <= 8; e++) begin
      tick();
      checks++;
      if (key !== ((e == 7) ? 4'b0001 : 4'b0000) || key_error !== 1'b0) begin
        errors++;
        $display("FAIL multi_full_release e=%0d: got key=%b err=%b required key=%b err=0",
                 e, key, key_error, ((e == 7) ? 4'b0001 : 4'b0000));
      end
    end
    idle(10);
  endtask

  task automatic test_release_bounce();
    logic [3:0] pat [10];
    pat = '{4'b1111, 4'b1111, 4'b1011, 4'b1011, 4'b1111,
            4'b1111, 4'b1011, 4'b1011, 4'b1111, 4'b1111};
    key_n = 4'b1011;
    for (int e = 1; e <= 10; e++) begin
      tick();
      checks++;
      if (key !== ((e == 7) ? 4'b0100 : 4'b0000) || key_held !== (e >= 7)) begin
        errors++;
        $display("FAIL rbounce_press e=%0d: got key=%b held=%b required key=%b held=%b",
                 e, key, key_held, ((e == 7) ? 4'b0100 : 4'b0000), (e >= 7));
      end
    end
    for (int e = 1; e <= 20; e++) begin
      if (e <= 10) key_n = pat[e-1];
      tick();
      checks++;
      if (key !== 4'b0000 || key_held !== (e < 15)) begin
        errors++;
        $display("FAIL rbounce_release e=%0d: got key=%b held=%b required key=0000 held=%b",
                 e, key, key_held, (e < 15));
      end
    end
    idle(5);
  endtask

  task automatic test_reset_mid();
    key_n = 4'b1110;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    checks++;
    if ({key, key_held, key_error} !== 6'b0) begin
      errors++;
      $display("FAIL midreset_outputs: got %b required 000000", {key, key_held, key_error});
    end
    reset = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      checks++;
      if (key !== ((e == 7) ? 4'b0001 : 4'b0000) || key_held !== (e >= 7) || key_error !== 1'b0) begin
        errors++;
        $display("FAIL midreset_repress e=%0d: got key=%b held=%b err=%b required key=%b held=%b err=0",
                 e, key, key_held, key_error, ((e == 7) ? 4'b0001 : 4'b0000), (e >= 7));
      end
    end
    idle(10);
  endtask

  task automatic test_repeat();
    logic [3:0] exp_key;
    key_n = 4'b0111;
    for (int e = 1; e <= 40; e++) begin
      if (e == 31) key_n = 4'b1111;
      tick();
      exp_key = (e == 7 || (REP && (e == 15 || e == 23 || e == 31))) ? 4'b1000 : 4'b0000;
      checks++;
      if (key !== exp_key || key_held !== (e >= 7 && e < 37)) begin
        errors++;
        $display("FAIL repeat e=%0d: got key=%b held=%b required key=%b held=%b",
                 e, key, key_held, exp_key, (e >= 7 && e < 37));
      end
    end
    idle(5);
  endtask

  initial begin
    reset = 1'b1;
    key_n = 4'b1111;
    test_reset();
    test_press();
    test_press_bounce();
    test_multi_key();
    test_release_bounce();
    test_reset_mid();
    test_repeat();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_press_conditioner.md
Name: key_press_conditioner

Overview:
- Sits directly upstream of the digital lock. Converts raw, bouncing, active-low push-button inputs into clean single-cycle active-high key events on the lock's 4-bit key input.
- Per-input synchroniser, then one shared debounce state machine. Accepts exactly one key at a time and flags multi-key presses.
- All logic is in the single clock domain.

Parameters:
- KEYS, 4, number of push-button inputs; width of key_n, key and key_code.
- SYNC_STAGES, 2, flip-flop stages per input in the synchroniser (minimum 2).
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required to accept a press or a release (minimum 2).
- REPEAT_CYCLES, 25000000, auto-repeat period in cycles. Used only with KEY_REPEAT_EN.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- key_n  input  KEYS  raw push buttons, active-low, asynchronous to clock.
- key  output  KEYS  one-hot key event, high for exactly one cycle per accepted press; feeds the lock's key input.
- key_held  output  1  high while an accepted key is considered held.
- key_error  output  1  one-cycle pulse when more than one key is seen pressed in IDLE.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values:
  - key=0, key_held=0, key_error=0.
  - Synchroniser stages preset to the released value (all ones on the key_n side).
  - Debounce counter=0, captured code=0, state=IDLE.
  - Reset asserted mid-operation aborts any debounce. No pulse is emitted in the cycle after reset.
- Synchronised pressed vector: p = ~key_n after SYNC_STAGES registers.
- The state machine uses p only. It never uses raw key_n.
- IDLE:
  - p==0: stay.
  - p exactly one-hot: capture it into the code register, clear the counter, go to DB_PRESS.
  - p has two or more bits set: pulse key_error for one cycle, go to WAIT_RELEASE.
- DB_PRESS:
  - p==code: counter increments.
  - p!=code: go to IDLE, counter cleared, no output.
  - Counter reaches DEBOUNCE_CYCLES-1 with p==code: go to PRESSED. key=code is registered for the next cycle only.
- PRESSED:
  - key_held=1.
  - p==0: clear counter, go to DB_RELEASE.
  - Any other non-zero p, including extra keys added: stay, no new pulse.
- DB_RELEASE:
  - key_held stays 1.
  - p==0: counter increments.
  - Any bit set: go back to PRESSED, no new pulse.
  - Counter reaches DEBOUNCE_CYCLES-1: go to IDLE, key_held=0.
- WAIT_RELEASE:
  - p!=0: stay, no key pulses.
  - p==0: counter increments. After DEBOUNCE_CYCLES consecutive released cycles, go to IDLE.
  - Any bit set during that count: counter cleared.
- Latency: a clean press stable from edge t produces key high during the cycle after edge t+SYNC_STAGES+DEBOUNCE_CYCLES. Bench check: rise exactly SYNC_STAGES+DEBOUNCE_CYCLES+1 edges after the first low sample.
- Outputs are registered. key is always 0 or one-hot, never multi-hot.
- Counter width is $clog2(DEBOUNCE_CYCLES)+1. It saturates and never wraps.

Optional Feature:
- KEY_REPEAT_EN defined:
  - In PRESSED, a repeat counter runs from entry.
  - Every REPEAT_CYCLES cycles held, key=code pulses again for one cycle.
  - The counter clears on leaving PRESSED and on return from DB_RELEASE. Held time spent in DB_RELEASE does not count.
- KEY_REPEAT_EN undefined:
  - No repeat counter is synthesised.
  - Exactly one pulse per press.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8):
- Reset asserted 2 cycles with key_n=4'b1111, then released -> key=0, key_held=0, key_error=0. No pulse over 20 idle cycles.
- key_n=4'b1101 from edge 0, held 20 cycles, then 4'b1111:
  - key=4'b0010 for exactly one cycle after edge 6 (edge 7).
  - key_held high from edge 7 until 4 released cycles after p clears.
  - No further pulse without KEY_REPEAT_EN.
- key_n=4'b1110 low for 2 cycles, high 1, low 2, high -> no key pulse, state returns to IDLE.
- key_n=4'b1100 -> key_error one pulse, key stays 0. Then 4'b1110 while still pressed -> no pulse. IDLE only after 4 cycles of 4'b1111.
- Release bounce: after an accepted 4'b0100 press, key_n toggles 4'b1111/4'b1011 every 2 cycles for 10 cycles, then stays 4'b1111 -> key_held stays 1 through the bounce. No second pulse. key_held falls 4 stable cycles later.
- Reset asserted at DB_PRESS count 2 -> next cycle all outputs 0, IDLE. Press reapplied -> pulse follows the full latency of 7 edges.
- KEY_REPEAT_EN defined, key_n=4'b0111 held 30 cycles -> key=4'b1000 at edge 7, then every 8 cycles (edges 15, 23, 31).
